// File: rtl/i2c_codec_responder_if.sv
// I2C bus pins between a bus master and the codec responder.
// The master drives SCL/SDA; the responder answers through the open-drain SDA enable.
interface i2c_codec_responder_if;
    logic scl;
    logic sda;
    logic sda_oe;

    modport master (
        output scl,
        output sda,
        input  sda_oe
    );

    modport slave (
        input  scl,
        input  sda,
        output sda_oe
    );
endinterface

// File: rtl/i2c_codec_responder.sv
// I2C write-only responder for a codec control port: 7-bit register
// address plus 9-bit data per two-byte write, into a 10-entry register file.
module i2c_codec_responder #(
    parameter logic [6:0] DEV_ADDR    = 7'h1A,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_scl,
    input  logic       i_sda,
    output logic       o_sda_oe,
    output logic       o_reg_we,
    output logic [6:0] o_reg_addr,
    output logic [8:0] o_reg_data,
    output logic       o_busy,
    output logic       o_addr_err,
    input  logic [3:0] i_rd_addr,
    output logic [8:0] o_rd_data
);

    localparam int         NREG    = 10;
    localparam logic [6:0] RST_REG = 7'h0F;
    localparam logic [7:0] WR_ADDR = {DEV_ADDR, 1'b0};

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_ACK_A,
        S_BYTE1,
        S_ACK_1,
        S_BYTE2,
        S_ACK_2,
        S_IGNORE
    } state_e;

    function automatic logic [8:0] rf_default(input int idx);
        logic [8:0] v;
        case (idx)
            0, 1:    v = 9'h097;
            2, 3:    v = 9'h079;
            4:       v = 9'h00A;
            5:       v = 9'h008;
            6:       v = 9'h09F;
            7:       v = 9'h00A;
            default: v = 9'h000;
        endcase
        return v;
    endfunction

    logic [SYNC_STAGES-1:0] scl_sync_q;
    logic [SYNC_STAGES-1:0] sda_sync_q;
    logic                   scl_prev_q;
    logic                   sda_prev_q;

    state_e     state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    logic [6:0] shreg_q, shreg_d;
    logic       ack_drv_q, ack_drv_d;
    logic [7:0] b1_q, b1_d;
    logic [7:0] b2_q, b2_d;
    logic       reg_we_q, reg_we_d;
    logic       addr_err_q, addr_err_d;
    logic [6:0] reg_addr_q;
    logic [8:0] reg_data_q;
    logic [8:0] rf_q [NREG];

    logic       scl_s, sda_s;
    logic       scl_rise, scl_fall;
    logic       start_ev, stop_ev;
    logic       last_bit;
    logic [7:0] byte_in;

    // Idle bus is high, so synchronizers reset to 1 to avoid a false event.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            scl_sync_q <= '1;
            sda_sync_q <= '1;
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
        end else begin
            for (int i = SYNC_STAGES - 1; i > 0; i--) begin
                scl_sync_q[i] <= scl_sync_q[i-1];
                sda_sync_q[i] <= sda_sync_q[i-1];
            end
            scl_sync_q[0] <= i_scl;
            sda_sync_q[0] <= i_sda;
            scl_prev_q    <= scl_s;
            sda_prev_q    <= sda_s;
        end
    end

    assign scl_s    = scl_sync_q[SYNC_STAGES-1];
    assign sda_s    = sda_sync_q[SYNC_STAGES-1];
    assign scl_rise = scl_s & ~scl_prev_q;
    assign scl_fall = ~scl_s & scl_prev_q;
    assign start_ev = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
    assign stop_ev  = scl_s & scl_prev_q & ~sda_prev_q & sda_s;
    assign byte_in  = {shreg_q, sda_s};
    assign last_bit = scl_rise & (cnt_q == 3'd7);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            shreg_q    <= '0;
            ack_drv_q  <= 1'b0;
            b1_q       <= '0;
            b2_q       <= '0;
            reg_we_q   <= 1'b0;
            addr_err_q <= 1'b0;
            reg_addr_q <= '0;
            reg_data_q <= '0;
            for (int i = 0; i < NREG; i++) begin
                rf_q[i] <= rf_default(i);
            end
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            shreg_q    <= shreg_d;
            ack_drv_q  <= ack_drv_d;
            b1_q       <= b1_d;
            b2_q       <= b2_d;
            reg_we_q   <= reg_we_d;
            addr_err_q <= addr_err_d;
            if (reg_we_d) begin
                reg_addr_q <= b1_q[7:1];
                reg_data_q <= {b1_q[0], b2_q};
                if (b1_q[7:1] == RST_REG) begin
                    for (int i = 0; i < NREG; i++) begin
                        rf_q[i] <= rf_default(i);
                    end
                end else if (b1_q[7:1] < 7'd10) begin
                    rf_q[b1_q[4:1]] <= {b1_q[0], b2_q};
                end
            end
        end
    end

    // ACK slot: first SCL fall drives SDA low, second fall releases it.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        shreg_d   = shreg_q;
        ack_drv_d = ack_drv_q;
        b1_d      = b1_q;
        b2_d      = b2_q;
        if (stop_ev) begin
            state_d   = S_IDLE;
            cnt_d     = '0;
            ack_drv_d = 1'b0;
        end else if (start_ev) begin
            state_d   = S_ADDR;
            cnt_d     = '0;
            shreg_d   = '0;
            ack_drv_d = 1'b0;
        end else begin
            case (state_q)
                S_ADDR, S_BYTE1, S_BYTE2: begin
                    if (scl_rise) begin
                        shreg_d = byte_in[6:0];
                        cnt_d   = cnt_q + 3'd1;
                    end
                    if (last_bit) begin
                        case (state_q)
                            S_ADDR: begin
                                state_d = (byte_in == WR_ADDR) ? S_ACK_A : S_IGNORE;
                            end
                            S_BYTE1: begin
                                b1_d    = byte_in;
                                state_d = S_ACK_1;
                            end
                            default: begin
                                b2_d    = byte_in;
                                state_d = S_ACK_2;
                            end
                        endcase
                    end
                end
                S_ACK_A, S_ACK_1, S_ACK_2: begin
                    if (scl_fall) begin
                        if (!ack_drv_q) begin
                            ack_drv_d = 1'b1;
                        end else begin
                            ack_drv_d = 1'b0;
                            cnt_d     = '0;
                            case (state_q)
                                S_ACK_A: state_d = S_BYTE1;
                                S_ACK_1: state_d = S_BYTE2;
                                default: state_d = S_IGNORE;
                            endcase
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        o_busy   = (state_q != S_IDLE);
        o_sda_oe = ack_drv_q & ((state_q == S_ACK_A) |
                                (state_q == S_ACK_1) |
                                (state_q == S_ACK_2));
        reg_we_d = (state_q == S_ACK_2) & ~ack_drv_q & scl_fall &
                   ~start_ev;
        addr_err_d = (state_q == S_ADDR) & last_bit & ~start_ev &
                     ~stop_ev & (byte_in != WR_ADDR);
    end

    assign o_reg_we   = reg_we_q;
    assign o_addr_err = addr_err_q;
    assign o_reg_addr = reg_addr_q;
    assign o_reg_data = reg_data_q;
    assign o_rd_data  = (i_rd_addr < 4'd10) ? rf_q[i_rd_addr] : 9'h000;

endmodule

// File: tb/tb_i2c_codec_responder.sv
// Directed plus random I2C write bench for the codec responder,
// checked against a register-file model kept in the bench.
module tb_i2c_codec_responder;

    localparam int Q = 6;

    logic       clk;
    logic       rst_n;
    logic       reg_we;
    logic [6:0] reg_addr;
    logic [8:0] reg_data;
    logic       busy;
    logic       addr_err;
    logic [3:0] rd_addr;
    logic [8:0] rd_data;
    logic       sda_line;

    i2c_codec_responder_if bus ();

    assign sda_line = bus.sda & ~bus.sda_oe;

    i2c_codec_responder dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_scl      (bus.scl),
        .i_sda      (sda_line),
        .o_sda_oe   (bus.sda_oe),
        .o_reg_we   (reg_we),
        .o_reg_addr (reg_addr),
        .o_reg_data (reg_data),
        .o_busy     (busy),
        .o_addr_err (addr_err),
        .i_rd_addr  (rd_addr),
        .o_rd_data  (rd_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_miss = 0;

    int         we_cnt  = 0;
    int         err_cnt = 0;
    logic       oe_seen = 1'b0;
    logic [6:0] we_addr = '0;
    logic [8:0] we_data = '0;

    always @(negedge clk) begin
        if (reg_we) begin
            we_cnt  <= we_cnt + 1;
            we_addr <= reg_addr;
            we_data <= reg_data;
        end
        if (addr_err) err_cnt <= err_cnt + 1;
        if (bus.sda_oe) oe_seen <= 1'b1;
    end

    logic [8:0] rf_m [10];

    function automatic logic [8:0] def_val(input int i);
        logic [8:0] d [10];
        d = '{9'h097, 9'h097, 9'h079, 9'h079, 9'h00A,
              9'h008, 9'h09F, 9'h00A, 9'h000, 9'h000};
        return d[i];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 10; i++) rf_m[i] = def_val(i);
    endtask

    task automatic model_write(input logic [6:0] a, input logic [8:0] d);
        if (a == 7'h0F) model_reset();
        else if (a < 7'd10) rf_m[a] = d;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_rf(input string tag);
        for (int i = 0; i < 16; i++) begin
            rd_addr = 4'(i);
            #1;
            chk($sformatf("%s rd%0d", tag, i), 32'(rd_data),
                (i < 10) ? 32'(rf_m[i]) : 32'h0);
        end
    endtask

    task automatic wq(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic i2c_start();
        bus.sda = 1'b1; wq(Q);
        bus.scl = 1'b1; wq(Q);
        bus.sda = 1'b0; wq(Q);
        bus.scl = 1'b0; wq(Q);
    endtask

    task automatic i2c_stop();
        bus.sda = 1'b0; wq(Q);
        bus.scl = 1'b1; wq(Q);
        bus.sda = 1'b1; wq(2 * Q);
    endtask

    task automatic i2c_bit(input logic b);
        bus.sda = b;    wq(Q);
        bus.scl = 1'b1; wq(2 * Q);
        bus.scl = 1'b0; wq(Q);
    endtask

    task automatic i2c_byte(input logic [7:0] b, output logic ack);
        for (int i = 7; i >= 0; i--) i2c_bit(b[i]);
        bus.sda = 1'b1; wq(Q);
        bus.scl = 1'b1; wq(Q);
        ack = ~sda_line;
        wq(Q);
        bus.scl = 1'b0; wq(Q);
    endtask

    logic       ack;
    int         we0, err0;
    logic [7:0] dev;
    logic [6:0] ra;
    logic [8:0] rd;
    logic       ok, extra;
    int         waited;

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n   = 1'b0;
        bus.scl = 1'b1;
        bus.sda = 1'b1;
        rd_addr = '0;
        model_reset();
        wq(4);
        chk("rst oe", 32'(bus.sda_oe), 32'h0);
        chk("rst busy", 32'(busy), 32'h0);
        chk("rst we", 32'(reg_we), 32'h0);
        chk("rst err", 32'(addr_err), 32'h0);
        rst_n = 1'b1;
        wq(4);
        chk("rst addr", 32'(reg_addr), 32'h0);
        chk("rst data", 32'(reg_data), 32'h0);
        chk_rf("rst");

        // Basic write R4 = 015
        we0 = we_cnt; err0 = err_cnt;
        i2c_start();
        chk("w1 busy", 32'(busy), 32'h1);
        i2c_byte(8'h34, ack); chk("w1 ackA", 32'(ack), 32'h1);
        i2c_byte(8'h08, ack); chk("w1 ack1", 32'(ack), 32'h1);
        i2c_byte(8'h15, ack); chk("w1 ack2", 32'(ack), 32'h1);
        i2c_stop();
        model_write(7'h04, 9'h015);
        chk("w1 we", 32'(we_cnt - we0), 32'h1);
        chk("w1 addr", 32'(we_addr), 32'h04);
        chk("w1 data", 32'(we_data), 32'h015);
        chk("w1 port addr", 32'(reg_addr), 32'h04);
        chk("w1 err", 32'(err_cnt - err0), 32'h0);
        chk("w1 busy end", 32'(busy), 32'h0);
        rd_addr = 4'd4; #1;
        chk("w1 rd4", 32'(rd_data), 32'h015);

        // Wrong device address
        we0 = we_cnt; err0 = err_cnt; oe_seen = 1'b0;
        i2c_start();
        i2c_byte(8'h36, ack); chk("bad ackA", 32'(ack), 32'h0);
        i2c_byte(8'h00, ack); chk("bad ack1", 32'(ack), 32'h0);
        i2c_byte(8'h97, ack); chk("bad ack2", 32'(ack), 32'h0);
        i2c_stop();
        chk("bad oe", 32'(oe_seen), 32'h0);
        chk("bad err", 32'(err_cnt - err0), 32'h1);
        chk("bad we", 32'(we_cnt - we0), 32'h0);
        chk_rf("bad");

        // Read request is refused
        we0 = we_cnt; err0 = err_cnt; oe_seen = 1'b0;
        i2c_start();
        i2c_byte(8'h35, ack); chk("rd ackA", 32'(ack), 32'h0);
        chk("rd err", 32'(err_cnt - err0), 32'h1);
        i2c_byte(8'h34, ack); chk("rd ign ack", 32'(ack), 32'h0);
        chk("rd ign busy", 32'(busy), 32'h1);
        i2c_stop();
        chk("rd oe", 32'(oe_seen), 32'h0);
        chk("rd busy end", 32'(busy), 32'h0);
        chk("rd we", 32'(we_cnt - we0), 32'h0);

        // R6 = 000 then register-file restore via address 0F
        i2c_start();
        i2c_byte(8'h34, ack);
        i2c_byte(8'h0C, ack);
        i2c_byte(8'h00, ack);
        i2c_stop();
        model_write(7'h06, 9'h000);
        rd_addr = 4'd6; #1;
        chk("r6 zero", 32'(rd_data), 32'h000);
        we0 = we_cnt;
        i2c_start();
        i2c_byte(8'h34, ack);
        i2c_byte(8'h1E, ack); chk("rst0F ack1", 32'(ack), 32'h1);
        i2c_byte(8'h00, ack); chk("rst0F ack2", 32'(ack), 32'h1);
        i2c_stop();
        model_write(7'h0F, 9'h000);
        chk("rst0F we", 32'(we_cnt - we0), 32'h1);
        chk("rst0F addr", 32'(we_addr), 32'h0F);
        chk_rf("rst0F");

        // STOP in the middle of byte 2
        we0 = we_cnt;
        i2c_start();
        i2c_byte(8'h34, ack);
        i2c_byte(8'h0C, ack);
        for (int i = 0; i < 4; i++) i2c_bit(1'b1);
        i2c_stop();
        chk("mid we", 32'(we_cnt - we0), 32'h0);
        chk("mid busy", 32'(busy), 32'h0);
        rd_addr = 4'd6; #1;
        chk("mid rd6", 32'(rd_data), 32'(rf_m[6]));

        // Repeated START discards a partial byte
        we0 = we_cnt;
        i2c_start();
        i2c_byte(8'h34, ack);
        for (int i = 0; i < 5; i++) i2c_bit(1'b0);
        i2c_start();
        i2c_byte(8'h34, ack); chk("rs ackA", 32'(ack), 32'h1);
        i2c_byte(8'h04, ack);
        i2c_byte(8'h77, ack);
        i2c_stop();
        model_write(7'h02, 9'h077);
        chk("rs we", 32'(we_cnt - we0), 32'h1);
        chk_rf("rs");

        // Random writes against the model
        for (int t = 0; t < 14; t++) begin
            ok = ($urandom_range(0, 7) != 0);
            dev = ok ? 8'h34 : 8'($urandom_range(0, 255) | 1);
            case ($urandom_range(0, 5))
                0:       ra = 7'h0F;
                1:       ra = 7'($urandom_range(10, 127));
                default: ra = 7'($urandom_range(0, 9));
            endcase
            rd    = 9'($urandom_range(0, 511));
            extra = ($urandom_range(0, 3) == 0);
            we0 = we_cnt; err0 = err_cnt;
            i2c_start();
            i2c_byte(dev, ack);
            chk($sformatf("rnd%0d ackA", t), 32'(ack), 32'(ok));
            i2c_byte({ra, rd[8]}, ack);
            i2c_byte(rd[7:0], ack);
            chk($sformatf("rnd%0d ack2", t), 32'(ack), 32'(ok));
            if (extra) begin
                i2c_byte(8'($urandom_range(0, 255)), ack);
                chk($sformatf("rnd%0d ack3", t), 32'(ack), 32'h0);
            end
            i2c_stop();
            if (ok) model_write(ra, rd);
            chk($sformatf("rnd%0d we", t), 32'(we_cnt - we0), 32'(ok));
            chk($sformatf("rnd%0d err", t), 32'(err_cnt - err0), 32'(!ok));
            if (ok) begin
                chk($sformatf("rnd%0d waddr", t), 32'(we_addr), 32'(ra));
                chk($sformatf("rnd%0d wdata", t), 32'(we_data), 32'(rd));
            end
            rd_addr = 4'($urandom_range(0, 15)); #1;
            chk($sformatf("rnd%0d rd", t), 32'(rd_data),
                (rd_addr < 10) ? 32'(rf_m[rd_addr]) : 32'h0);
        end
        chk_rf("rnd");

        // Make R1 non-default, then reset during the ACK_1 slot
        i2c_start();
        i2c_byte(8'h34, ack);
        i2c_byte(8'h03, ack);
        i2c_byte(8'h2C, ack);
        i2c_stop();
        we0 = we_cnt;
        i2c_start();
        i2c_byte(8'h34, ack);
        for (int i = 7; i >= 0; i--) i2c_bit(i[0]);
        bus.sda = 1'b1;
        waited = 0;
        while (!bus.sda_oe && waited < 4 * Q) begin
            @(negedge clk);
            waited++;
        end
        chk("ra1 oe up", 32'(bus.sda_oe), 32'h1);
        rst_n = 1'b0;
        #1;
        chk("ra1 oe drop", 32'(bus.sda_oe), 32'h0);
        chk("ra1 busy", 32'(busy), 32'h0);
        bus.scl = 1'b1;
        bus.sda = 1'b1;
        wq(4);
        rst_n = 1'b1;
        wq(4);
        model_reset();
        chk("ra1 we", 32'(we_cnt - we0), 32'h0);
        chk_rf("ra1");
        we0 = we_cnt;
        i2c_start();
        i2c_byte(8'h34, ack); chk("post ackA", 32'(ack), 32'h1);
        i2c_byte(8'h0E, ack);
        i2c_byte(8'h55, ack); chk("post ack2", 32'(ack), 32'h1);
        i2c_stop();
        model_write(7'h07, 9'h055);
        chk("post we", 32'(we_cnt - we0), 32'h1);
        chk_rf("post");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/i2c_codec_responder.md
I2C_CODEC_RESPONDER -- requirements
Module: i2c_codec_responder

Interface
REQ-001 SHALL have parameter DEV_ADDR, default 7'h1A: the 7-bit device address it responds to.
REQ-002 SHALL have parameter SYNC_STAGES, default 2: flop count in each SCL/SDA input synchronizer.
REQ-003 SHALL have port i_clk  input  1: the single clock, at least 8x the SCL rate.
REQ-004 SHALL have port i_rst_n  input  1: reset, asynchronous, active-low.
REQ-005 SHALL have port i_scl  input  1: I2C clock from the bus (asynchronous to i_clk).
REQ-006 SHALL have port i_sda  input  1: I2C data as seen on the bus (asynchronous to i_clk).
REQ-007 SHALL have port o_sda_oe  output  1: 1 = pull SDA low (open-drain); 0 = release.
REQ-008 SHALL have port o_reg_we  output  1: one-cycle commit strobe.
REQ-009 SHALL have port o_reg_addr  output  7: register address of the last commit.
REQ-010 SHALL have port o_reg_data  output  9: register data of the last commit.
REQ-011 SHALL have port o_busy  output  1: a transaction is in progress.
REQ-012 SHALL have port o_addr_err  output  1: one-cycle pulse on an address mismatch or a read request.
REQ-013 SHALL have port i_rd_addr  input  4: register-file readback index.
REQ-014 SHALL have port o_rd_data  output  9: combinational readback value; 0 when i_rd_addr > 9.

Function
REQ-015 SHALL synchronize i_scl and i_sda through SYNC_STAGES flops and detect all bus events on the synchronized copies only.
REQ-016 SHALL detect START as synced SDA falling while synced SCL is high, and STOP as synced SDA rising while synced SCL is high.
REQ-017 SHALL implement these states: IDLE, ADDR, ACK_A, BYTE1, ACK_1, BYTE2, ACK_2, IGNORE.
REQ-018 SHALL sample SDA on each synced SCL rising edge, MSB first, 8 bits per byte, counting bits with a 3-bit counter.
REQ-019 SHALL go to ADDR on START from any state (repeated START included), clearing the bit counter and discarding any partial data.
REQ-020 SHALL go to IDLE on STOP from any state, drop o_busy, and release SDA.
REQ-021 SHALL, in ADDR after 8 bits, go to ACK_A when the byte equals {DEV_ADDR, 0}; otherwise it SHALL pulse o_addr_err and go to IGNORE without driving SDA.
REQ-022 SHALL assert o_sda_oe on the synced SCL falling edge after the 8th bit when an ACK is due, hold it through the 9th clock, and release it on the following SCL falling edge.
REQ-023 SHALL decode BYTE1 as {reg_addr[6:0], data[8]} and BYTE2 as data[7:0].
REQ-024 SHALL, at the cycle o_sda_oe rises in ACK_2, pulse o_reg_we for one cycle with o_reg_addr/o_reg_data valid in that same cycle; these outputs SHALL hold their values until the next commit.
REQ-025 SHALL write the 10-entry x 9-bit register file for reg_addr 0..9 in the commit cycle.
REQ-026 SHALL, when reg_addr = 7'h0F, restore the register-file defaults instead of writing.
REQ-027 SHALL ACK and strobe o_reg_we for any other reg_addr, without storing the value.
REQ-028 SHALL NACK a third data byte after ACK_2 (leave SDA released) and go to IGNORE.
REQ-029 SHALL leave IGNORE only on START or STOP.
REQ-030 SHALL drive o_busy high from START until STOP.
REQ-031 SHALL never drive SDA outside an ACK slot.
REQ-032 SHALL make no commit when a START or STOP lands mid-byte.
REQ-033 SHALL keep a commit made in the same cycle as a STOP (commit first).

Reset
REQ-034 SHALL, while i_rst_n = 0, immediately force o_sda_oe, o_reg_we, o_busy and o_addr_err to 0.
REQ-035 SHALL reset o_reg_addr and o_reg_data to 0 and the FSM to IDLE.
REQ-036 SHALL reset the register file to these defaults: R0 097, R1 097, R2 079, R3 079, R4 00A, R5 008, R6 09F, R7 00A, R8 000, R9 000 (hex).
REQ-037 SHALL abort any in-flight transfer on reset, with no commit, including when reset asserts mid-ACK.

Verification
REQ-038 The bench SHALL cover: START, 34, 08, 15, STOP -> three ACKs; o_reg_we pulses once with addr 04 and data 015; readback 4 = 015; o_busy ends low.
REQ-039 The bench SHALL cover: START, 36, 00, 97, STOP -> SDA never driven; o_addr_err pulses once; no o_reg_we; register file unchanged.
REQ-040 The bench SHALL cover: START, 35 (read bit set) -> NACK; o_addr_err pulse; IGNORE until STOP.
REQ-041 The bench SHALL cover: write R6 = 000, then START, 34, 1E, 00, STOP -> commit with addr 0F; readback 6 = 09F.
REQ-042 The bench SHALL cover: START, 34, 0C, then STOP after 4 bits of byte 2 -> no o_reg_we; R6 unchanged; o_busy low after STOP.
REQ-043 The bench SHALL cover: i_rst_n low during the ACK_1 slot -> o_sda_oe = 0 in the same cycle; defaults restored; a subsequent full write succeeds.
